// File: rtl/iddr_align_pkg.sv
// Shared definitions for the IDDR training-pattern word aligner.
//   state_t         : aligner FSM states
//   DEFAULT_PATTERN : training word sent by the far end during training
//   rot4()          : rotate a 4-bit word left by n positions. The aligner uses it
//                     to check that the pattern can be aligned unambiguously, and
//                     gearbox models use it to predict the word at a given offset.
package iddr_align_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_SETTLE,
    S_LOCK,
    S_FAIL
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0011;

  function automatic logic [3:0] rot4(input logic [3:0] word, input logic [1:0] n);
    logic [7:0] dbl;
    dbl = {word, word} << n;
    return dbl[7:4];
  endfunction

endpackage

// File: rtl/iddr_align_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk  : clock
//   rstn : synchronous active-low reset (count -> 0)
//   clr  : clear to 0; takes priority over inc
//   inc  : increment by one, holding at MAX instead of wrapping
//   cnt  : current count
module iddr_align_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/iddr_word_align.sv
// Training-pattern word aligner placed after a 1:4 DDR input gearbox.
// The gearbox word is registered, compared against PATTERN, and on mismatch a
// single-cycle ALIGNWD slip request is sent back. After each slip the gearbox
// pipeline is given SETTLE cycles, then MATCH_CNT consecutive matches declare
// lock. While locked and TRAIN_EN=1, LOSS_CNT consecutive mismatches drop lock.
//   SCLK      : word clock
//   RSTN      : synchronous active-low reset
//   Q         : gearbox word {Q3,Q2,Q1,Q0}
//   TRAIN_EN  : 1 = train / keep monitoring, 0 = idle or data mode when locked
//   ALIGNWD   : slip request, one SCLK cycle per slip
//   LOCKED    : alignment achieved
//   ALIGN_ERR : MAX_SLIPS used up without lock; held until TRAIN_EN=0
//   DOUT      : Q delayed by two cycles
//   DVALID    : equals LOCKED, aligned with DOUT
//   SLIPS     : slips issued in the current attempt
module iddr_word_align
  import iddr_align_pkg::*;
#(
  parameter logic [3:0] PATTERN   = DEFAULT_PATTERN,
  parameter int         MATCH_CNT = 8,
  parameter int         SETTLE    = 4,
  parameter int         LOSS_CNT  = 4,
  parameter int         MAX_SLIPS = 8
) (
  input  logic                           SCLK,
  input  logic                           RSTN,
  input  logic [3:0]                     Q,
  input  logic                           TRAIN_EN,
  output logic                           ALIGNWD,
  output logic                           LOCKED,
  output logic                           ALIGN_ERR,
  output logic [3:0]                     DOUT,
  output logic                           DVALID,
  output logic [$clog2(MAX_SLIPS+1)-1:0] SLIPS
);

  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int TW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int CW = $clog2(MAX_SLIPS + 1);

  // A pattern equal to one of its own rotations cannot identify word alignment.
  if ((rot4(PATTERN, 2'd1) == PATTERN) || (rot4(PATTERN, 2'd2) == PATTERN) ||
      (MATCH_CNT < 1) || (SETTLE < 2) || (LOSS_CNT < 1) || (MAX_SLIPS < 1)) begin : g_bad_params
    $error("iddr_word_align: illegal parameter set");
  end

  state_t        state_reg, state_next;
  logic [3:0]    q_reg, dout_reg;
  logic          alignwd_reg, locked_reg, align_err_reg;
  logic          armed_reg;
  logic          match;
  logic [MW-1:0] match_cnt;
  logic [TW-1:0] settle_cnt;
  logic [LW-1:0] loss_cnt;
  logic [CW-1:0] slip_cnt;
  logic          match_inc, match_clr, settle_inc, settle_clr;
  logic          loss_inc, loss_clr, slip_inc, slip_clr;

  assign match = (q_reg == PATTERN);

  iddr_align_cnt #(.MAX(MATCH_CNT)) u_match_cnt (
    .clk(SCLK), .rstn(RSTN), .clr(match_clr), .inc(match_inc), .cnt(match_cnt));
  iddr_align_cnt #(.MAX(SETTLE)) u_settle_cnt (
    .clk(SCLK), .rstn(RSTN), .clr(settle_clr), .inc(settle_inc), .cnt(settle_cnt));
  iddr_align_cnt #(.MAX(LOSS_CNT)) u_loss_cnt (
    .clk(SCLK), .rstn(RSTN), .clr(loss_clr), .inc(loss_inc), .cnt(loss_cnt));
  iddr_align_cnt #(.MAX(MAX_SLIPS)) u_slip_cnt (
    .clk(SCLK), .rstn(RSTN), .clr(slip_clr), .inc(slip_inc), .cnt(slip_cnt));

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    match_inc  = 1'b0;
    match_clr  = 1'b0;
    settle_inc = 1'b0;
    settle_clr = 1'b0;
    loss_inc   = 1'b0;
    loss_clr   = 1'b0;
    slip_inc   = 1'b0;
    slip_clr   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (TRAIN_EN) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!TRAIN_EN) begin
          state_next = S_IDLE;
        end else if (armed_reg) begin
          // The word seen on the first CHECK cycle was captured before CHECK was
          // entered, so only words captured while in CHECK are counted.
          if (match) begin
            match_inc = 1'b1;
            if (match_cnt == MW'(MATCH_CNT - 1)) begin
              state_next = S_LOCK;
              match_clr  = 1'b1;
            end
          end else begin
            match_clr = 1'b1;
            if (slip_cnt == CW'(MAX_SLIPS)) begin
              state_next = S_FAIL;
            end else begin
              state_next = S_SLIP;
              slip_inc   = 1'b1;  // SLIPS rises together with ALIGNWD
            end
          end
        end
      end
      S_SLIP: begin
        settle_clr = 1'b1;
        state_next = TRAIN_EN ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (!TRAIN_EN) begin
          state_next = S_IDLE;
        end else if (settle_cnt == TW'(SETTLE - 1)) begin
          state_next = S_CHECK;
          match_clr  = 1'b1;
        end else begin
          settle_inc = 1'b1;
        end
      end
      S_LOCK: begin
        if (!TRAIN_EN) begin
          loss_clr = 1'b1;  // data mode: lock is held whatever arrives
        end else if (match) begin
          loss_clr = 1'b1;
        end else if (loss_cnt == LW'(LOSS_CNT - 1)) begin
          state_next = S_CHECK;
          loss_clr   = 1'b1;
          slip_clr   = 1'b1;
          match_clr  = 1'b1;
        end else begin
          loss_inc = 1'b1;
        end
      end
      S_FAIL: begin
        if (!TRAIN_EN) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_IDLE) begin
      match_clr  = 1'b1;
      settle_clr = 1'b1;
      loss_clr   = 1'b1;
      slip_clr   = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as
  // the state itself.
  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      q_reg         <= '0;
      dout_reg      <= '0;
      alignwd_reg   <= 1'b0;
      locked_reg    <= 1'b0;
      align_err_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      q_reg         <= Q;
      dout_reg      <= q_reg;
      alignwd_reg   <= (state_next == S_SLIP);
      locked_reg    <= (state_next == S_LOCK);
      align_err_reg <= (state_next == S_FAIL);
      armed_reg     <= (state_reg == S_CHECK);
    end
  end

  assign ALIGNWD   = alignwd_reg;
  assign LOCKED    = locked_reg;
  assign DVALID    = locked_reg;
  assign ALIGN_ERR = align_err_reg;
  assign DOUT      = dout_reg;
  assign SLIPS     = slip_cnt;

  // The gearbox edge-detects ALIGNWD, so back-to-back high cycles would merge.
  a_single_slip: assert property (@(posedge SCLK) disable iff (!RSTN) ALIGNWD |=> !ALIGNWD);

endmodule

// File: tb/tb_iddr_word_align.sv
// Self-checking bench for iddr_word_align with a rotating-gearbox model: each
// ALIGNWD pulse advances the gearbox offset by one position.
module tb_iddr_word_align;
  import iddr_align_pkg::*;

  localparam logic [3:0] PAT = 4'b0011;

  logic       SCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       TRAIN_EN = 1'b0;
  logic [3:0] Q = 4'b0000;
  logic       ALIGNWD, LOCKED, ALIGN_ERR, DVALID;
  logic [3:0] DOUT;
  logic [3:0] SLIPS;

  iddr_word_align dut (
    .SCLK(SCLK), .RSTN(RSTN), .Q(Q), .TRAIN_EN(TRAIN_EN),
    .ALIGNWD(ALIGNWD), .LOCKED(LOCKED), .ALIGN_ERR(ALIGN_ERR),
    .DOUT(DOUT), .DVALID(DVALID), .SLIPS(SLIPS));

  always #5 SCLK = ~SCLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         pulse_cnt, last_pulse, min_gap, wide_cnt;
  bit         prev_aw = 1'b0;
  int         offset = 0;
  bit         use_force = 1'b0;
  logic [3:0] force_q = 4'b0000;
  logic [3:0] exp_q[$];

  // One clock: sample outputs 1 time unit after the edge, run the gearbox model,
  // then drive the next word.
  task automatic step();
    @(posedge SCLK);
    #1;
    cyc++;
    if (ALIGNWD === 1'b1) begin
      if (prev_aw) wide_cnt++;
      if (last_pulse >= 0 && (cyc - last_pulse - 1) < min_gap) min_gap = cyc - last_pulse - 1;
      last_pulse = cyc;
      pulse_cnt++;
      offset = (offset + 1) % 4;
    end
    prev_aw = (ALIGNWD === 1'b1);
    Q = use_force ? force_q : rot4(PAT, offset[1:0]);
  endtask

  task automatic clear_stats();
    pulse_cnt  = 0;
    last_pulse = -1;
    min_gap    = 1000;
    wide_cnt   = 0;
  endtask

  task automatic do_reset(input int start_off);
    RSTN      = 1'b0;
    TRAIN_EN  = 1'b0;
    use_force = 1'b0;
    offset    = start_off;
    Q         = rot4(PAT, offset[1:0]);
    repeat (3) step();
    RSTN = 1'b1;
    step();
    clear_stats();
  endtask

  task automatic train_to_lock(output int lat);
    TRAIN_EN = 1'b1;
    lat = 0;
    while (LOCKED !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; TRAIN_EN = 1'b1; Q = 4'b1010;
    repeat (3) step();
    n_cmp++;
    if ({ALIGNWD, LOCKED, DVALID, ALIGN_ERR} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {ALIGNWD, LOCKED, DVALID, ALIGN_ERR});
    end
    n_cmp++;
    if ({DOUT, SLIPS} !== 8'h00) begin
      n_bad++; $display("FAIL reset_data: DOUT=%h SLIPS=%0d expected 0/0", DOUT, SLIPS);
    end
    $display("test_reset: outputs idle under reset");
  endtask

  task automatic test_lock_offset0();
    do_reset(0);
    TRAIN_EN = 1'b1;
    repeat (9) step();
    n_cmp++;
    if (LOCKED !== 1'b0) begin
      n_bad++; $display("FAIL lock0_early: LOCKED=%b expected 0 after 9 cycles", LOCKED);
    end
    step();
    n_cmp++;
    if ({LOCKED, DVALID} !== 2'b11) begin
      n_bad++; $display("FAIL lock0_latency: LOCKED/DVALID=%b expected 11 after 10 cycles", {LOCKED, DVALID});
    end
    n_cmp++;
    if (DOUT !== PAT) begin
      n_bad++; $display("FAIL lock0_dout: DOUT=%b expected %b", DOUT, PAT);
    end
    n_cmp++;
    if (pulse_cnt != 0 || SLIPS !== 4'd0) begin
      n_bad++; $display("FAIL lock0_noslip: pulses=%0d SLIPS=%0d expected 0/0", pulse_cnt, SLIPS);
    end
    $display("test_lock_offset0: locked with %0d slips", pulse_cnt);
  endtask

  task automatic test_slip_offset2();
    int lat;
    do_reset(2);
    train_to_lock(lat);
    n_cmp++;
    if (LOCKED !== 1'b1) begin
      n_bad++; $display("FAIL slip2_lock: LOCKED=%b expected 1 within 300 cycles", LOCKED);
    end
    n_cmp++;
    if (pulse_cnt != 2 || SLIPS !== 4'd2) begin
      n_bad++; $display("FAIL slip2_count: pulses=%0d SLIPS=%0d expected 2/2", pulse_cnt, SLIPS);
    end
    n_cmp++;
    if (wide_cnt != 0 || min_gap < 5) begin
      n_bad++; $display("FAIL slip2_shape: wide=%0d min_gap=%0d expected 0 and >=5", wide_cnt, min_gap);
    end
    $display("test_slip_offset2: lock after %0d cycles, %0d slips", lat, pulse_cnt);
  endtask

  task automatic test_fail();
    int n;
    do_reset(0);
    use_force = 1'b1; force_q = 4'b0000; Q = 4'b0000;
    TRAIN_EN = 1'b1;
    n = 0;
    while (ALIGN_ERR !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    n_cmp++;
    if (ALIGN_ERR !== 1'b1 || SLIPS !== 4'd8 || pulse_cnt != 8) begin
      n_bad++; $display("FAIL fail_entry: ALIGN_ERR=%b SLIPS=%0d pulses=%0d expected 1/8/8", ALIGN_ERR, SLIPS, pulse_cnt);
    end
    repeat (10) step();
    n_cmp++;
    if (ALIGN_ERR !== 1'b1 || pulse_cnt != 8 || LOCKED !== 1'b0) begin
      n_bad++; $display("FAIL fail_hold: ALIGN_ERR=%b pulses=%0d LOCKED=%b expected 1/8/0", ALIGN_ERR, pulse_cnt, LOCKED);
    end
    TRAIN_EN = 1'b0;
    step();
    n_cmp++;
    if (ALIGN_ERR !== 1'b0 || SLIPS !== 4'd0 || dut.state_reg !== S_IDLE) begin
      n_bad++; $display("FAIL fail_clear: ALIGN_ERR=%b SLIPS=%0d state=%0d expected 0/0/IDLE", ALIGN_ERR, SLIPS, dut.state_reg);
    end
    $display("test_fail: ALIGN_ERR after %0d slips, cleared by TRAIN_EN=0", pulse_cnt);
  endtask

  task automatic test_loss();
    int lat;
    int drops;
    do_reset(0);
    train_to_lock(lat);
    use_force = 1'b1; force_q = 4'b0101; Q = force_q;
    repeat (3) step();
    use_force = 1'b0; Q = rot4(PAT, offset[1:0]);
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (LOCKED !== 1'b1) drops++;
    end
    n_cmp++;
    if (drops != 0) begin
      n_bad++; $display("FAIL loss_three: LOCKED low on %0d cycles expected 0", drops);
    end
    use_force = 1'b1; Q = force_q;
    repeat (4) step();
    n_cmp++;
    if (LOCKED !== 1'b1) begin
      n_bad++; $display("FAIL loss_early: LOCKED=%b expected 1 before 4th mismatch is judged", LOCKED);
    end
    step();
    n_cmp++;
    if (LOCKED !== 1'b0 || DVALID !== 1'b0 || SLIPS !== 4'd0) begin
      n_bad++; $display("FAIL loss_drop: LOCKED=%b DVALID=%b SLIPS=%0d expected 0/0/0", LOCKED, DVALID, SLIPS);
    end
    clear_stats();
    for (int i = 0; i < 12 && pulse_cnt == 0; i++) step();
    n_cmp++;
    if (pulse_cnt != 1) begin
      n_bad++; $display("FAIL loss_slip: pulses=%0d expected 1 within 12 cycles", pulse_cnt);
    end
    use_force = 1'b0;
    $display("test_loss: lock dropped after 4 mismatches, slip issued");
  endtask

  task automatic test_data_mode();
    int lat;
    logic [3:0] exp;
    do_reset(0);
    train_to_lock(lat);
    TRAIN_EN = 1'b0;
    clear_stats();
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      force_q = 4'($urandom_range(0, 15));
      use_force = 1'b1;
      Q = force_q;
      exp_q.push_back(force_q);
      step();
      n_cmp++;
      if ({LOCKED, DVALID} !== 2'b11) begin
        n_bad++; $display("FAIL data_lock[%0d]: LOCKED/DVALID=%b expected 11", i, {LOCKED, DVALID});
      end
      if (i >= 1) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (DOUT !== exp) begin
          n_bad++; $display("FAIL data_dout[%0d]: DOUT=%h expected %h", i, DOUT, exp);
        end
      end
    end
    n_cmp++;
    if (pulse_cnt != 0) begin
      n_bad++; $display("FAIL data_noslip: pulses=%0d expected 0", pulse_cnt);
    end
    use_force = 1'b0;
    $display("test_data_mode: 100 words forwarded in data mode");
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    TRAIN_EN = 1'b1;
    for (int i = 0; i < 20 && pulse_cnt == 0; i++) step();
    step();
    n_cmp++;
    if (pulse_cnt != 1 || SLIPS !== 4'd1 || dut.state_reg !== S_SETTLE) begin
      n_bad++; $display("FAIL rstmid_setup: pulses=%0d SLIPS=%0d state=%0d expected 1/1/SETTLE", pulse_cnt, SLIPS, dut.state_reg);
    end
    RSTN = 1'b0;
    step();
    n_cmp++;
    if ({ALIGNWD, LOCKED, DVALID, ALIGN_ERR, DOUT, SLIPS} !== 12'h000 || dut.state_reg !== S_IDLE) begin
      n_bad++; $display("FAIL rstmid_clear: outs=%h state=%0d expected 000/IDLE",
                        {ALIGNWD, LOCKED, DVALID, ALIGN_ERR, DOUT, SLIPS}, dut.state_reg);
    end
    RSTN = 1'b1;
    $display("test_reset_mid: reset during SETTLE cleared all outputs");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    test_reset();
    test_lock_offset0();
    test_slip_offset2();
    test_fail();
    test_loss();
    test_data_mode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
